// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage integer pipeline.
// Merges the hazard and busy requests into a per-stage hold vector. MEM-stage
// exceptions and ERETs become a one-cycle flush with a redirect PC. A short
// drain window follows each flush, and stall/flush activity feeds the
// performance counters and the stall watchdog.
module pipeline_stall_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'hBFC0_0380,
  parameter int unsigned DRAIN_CYCLES  = 2,     // 1..15
  parameter int unsigned STALL_TIMEOUT = 1024   // 2..65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req_id_1,
  input  logic        stall_req_id_2,
  input  logic        stall_req_ex,
  input  logic        stall_req_mem,
  input  logic        exc_valid,
  input  logic        exc_is_eret,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        draining,
  output logic        stall_timeout,
  output logic [31:0] stall_cycle_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

  localparam logic [3:0]  DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
  localparam logic [15:0] RUN_LIMIT  = 16'(STALL_TIMEOUT - 1);

  // Stage hold patterns: a stall at stage N holds N and everything upstream.
  localparam logic [5:0] HOLD_MEM = 6'b011111;
  localparam logic [5:0] HOLD_EX  = 6'b001111;
  localparam logic [5:0] HOLD_ID  = 6'b000111;

  state_e      state_q;
  logic [3:0]  drain_cnt_q;
  logic        draining_q;
  logic [15:0] run_cnt_q;
  logic        timeout_q;
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  logic        id_req;
  logic        exc_acc;
  logic [5:0]  stall_d;
  logic        flush_d;
  logic [31:0] new_pc_d;
  logic        any_stall;

  // Zero-latency request arbitration; the drain window masks ID and exceptions.
  always_comb begin
    id_req   = (stall_req_id_1 | stall_req_id_2) & ~draining_q;
    exc_acc  = exc_valid & ~draining_q;
    stall_d  = '0;
    flush_d  = 1'b0;
    new_pc_d = '0;
    if (!rst) begin
      stall_d  = '0;
    end else if (exc_acc) begin
      // Flush wins outright; every stall request is dropped this cycle.
      flush_d  = 1'b1;
      new_pc_d = exc_is_eret ? cp0_epc : EXC_VECTOR;
    end else if (stall_req_mem) begin
      stall_d  = HOLD_MEM;
    end else if (stall_req_ex) begin
      stall_d  = HOLD_EX;
    end else if (id_req) begin
      stall_d  = HOLD_ID;
    end
  end

  assign any_stall = |stall_d;

  // RUN/DRAIN sequencer: a flush opens a fixed-length drain window.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
      draining_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (exc_acc) begin
            state_q     <= DRAIN;
            drain_cnt_q <= DRAIN_INIT;
            draining_q  <= 1'b1;
          end
        end
        DRAIN: begin
          // MEM/EX stalls do not pause the count; the window is time-based.
          if (drain_cnt_q == 4'd0) begin
            state_q    <= RUN;
            draining_q <= 1'b0;
          end else begin
            drain_cnt_q <= drain_cnt_q - 4'd1;
          end
        end
        default: begin
          state_q     <= RUN;
          drain_cnt_q <= '0;
          draining_q  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (any_stall && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_d && (flush_cnt_q != 16'hFFFF))
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  // Watchdog: length of the current unbroken stall run, sticky trip flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      run_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else if (any_stall && !flush_d) begin
      if (run_cnt_q == RUN_LIMIT)
        timeout_q <= 1'b1;
      // Saturate so a very long run never wraps back through the limit.
      if (run_cnt_q != 16'hFFFF)
        run_cnt_q <= run_cnt_q + 16'd1;
    end else begin
      run_cnt_q <= '0;
    end
  end

  assign stall           = stall_d;
  assign flush           = flush_d;
  assign new_pc          = new_pc_d;
  assign draining        = draining_q;
  assign stall_timeout   = timeout_q;
  assign stall_cycle_cnt = stall_cnt_q;
  assign flush_cnt       = flush_cnt_q;

endmodule
